ins_fetch: RTL and testbench



---
 rtl/bythoven_pkg.sv | 25 ++
 rtl/ins_byte_assembler.sv | 38 +++
 rtl/ins_fetch.sv | 109 ++++++++++
 tb/tb_ins_fetch.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bythoven_pkg.sv
// Shared definitions for the Bythoven CPU front end: sizes, fetch states,
// decode field positions and the pc legality rule.
package bythoven_pkg;

  localparam int unsigned INS_BYTES = 4;
  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned PC_W      = 64;
  localparam int unsigned INS_W     = 32;

  // Note-class field of an instruction word, consumed by decode.
  localparam int unsigned NOTE_CLASS_MSB = 30;
  localparam int unsigned NOTE_CLASS_LSB = 23;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  // A pc is fetchable when word aligned and inside the instruction memory.
  function automatic logic pc_legal(input logic [PC_W-1:0] pc, input int unsigned aw);
    return (pc[1:0] == 2'b00) && ((pc >> aw) == '0);
  endfunction

endpackage

// File: rtl/ins_byte_assembler.sv
// Collects four memory bytes, most significant first, into one instruction
// word. done_o flags the cycle whose edge captures the final byte.
module ins_byte_assembler
  import bythoven_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture_i,
  input  logic             clear_i,
  input  logic [7:0]       rdata_i,
  output logic [1:0]       cnt_o,
  output logic [INS_W-1:0] word_o,
  output logic             done_o
);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (clear_i) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (capture_i) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= {shift_q[15:0], rdata_i};
    end
  end

  assign cnt_o  = cnt_q;
  assign word_o = {shift_q, rdata_i};
  assign done_o = capture_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch stage: walks pc through byte-wide instruction memory,
// hands assembled words to decode over valid/ready, handles redirects/faults.
module ins_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned MEM_AW    = 10,
  parameter int unsigned INS_BYTES = 4
) (
  input  logic              clkOut,
  input  logic              rstN,
  output logic [MEM_AW-1:0] raddr,
  input  logic [7:0]        rdata,
  input  logic              redirectValid,
  input  logic [63:0]       redirectPc,
  output logic              insValid,
  input  logic              insReady,
  output logic [31:0]       curIns,
  output logic [63:0]       insPc,
  output logic              fetchFault
);

  import bythoven_pkg::*;

  localparam fetch_state_e RESET_STATE = pc_legal(RESET_PC, MEM_AW) ? ST_FETCH : ST_FAULT;

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  ins_pc_q, ins_pc_d;
  logic [31:0]  cur_ins_q, cur_ins_d;
  logic [63:0]  pc_inc;
  logic         capture;
  logic         asm_done;
  logic [1:0]   byte_cnt;
  logic [31:0]  asm_word;

  assign pc_inc = pc_q + 64'(INS_BYTES);

  ins_byte_assembler u_asm (
    .clk       (clkOut),
    .rst_n     (rstN),
    .capture_i (capture),
    .clear_i   (redirectValid),
    .rdata_i   (rdata),
    .cnt_o     (byte_cnt),
    .word_o    (asm_word),
    .done_o    (asm_done)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ins_pc_d  = ins_pc_q;
    cur_ins_d = cur_ins_q;
    capture   = 1'b0;
    raddr     = '0;

    case (state_q)
      ST_FETCH: begin
        raddr   = pc_q[MEM_AW-1:0] + MEM_AW'(byte_cnt);
        capture = 1'b1;
        if (asm_done) begin
          state_d   = ST_HOLD;
          cur_ins_d = asm_word;
          ins_pc_d  = pc_q;
        end
      end
      ST_HOLD: begin
        raddr = pc_q[MEM_AW-1:0] + MEM_AW'(INS_BYTES - 1);
        if (insReady) begin
          pc_d    = pc_inc;
          state_d = pc_legal(pc_inc, MEM_AW) ? ST_FETCH : ST_FAULT;
        end
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase

    // A redirect overrides everything, including a word accepted this cycle.
    if (redirectValid) begin
      pc_d      = redirectPc;
      state_d   = pc_legal(redirectPc, MEM_AW) ? ST_FETCH : ST_FAULT;
      capture   = 1'b0;
      cur_ins_d = cur_ins_q;
      ins_pc_d  = ins_pc_q;
    end
  end

  always_ff @(posedge clkOut or negedge rstN) begin
    if (!rstN) begin
      state_q   <= RESET_STATE;
      pc_q      <= RESET_PC;
      ins_pc_q  <= RESET_PC;
      cur_ins_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ins_pc_q  <= ins_pc_d;
      cur_ins_q <= cur_ins_d;
    end
  end

  assign insValid   = (state_q == ST_HOLD);
  assign fetchFault = (state_q == ST_FAULT);
  assign curIns     = cur_ins_q;
  assign insPc      = ins_pc_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: byte memory model, scoreboard of
// expected {word, pc}, a redirect vector table and hand-written corner cases.
module tb_ins_fetch;

  localparam int unsigned MEM_AW = 10;

  logic              clk;
  logic              rstN;
  logic [MEM_AW-1:0] raddr;
  logic [7:0]        rdata;
  logic              redirectValid;
  logic [63:0]       redirectPc;
  logic              insValid;
  logic              insReady;
  logic [31:0]       curIns;
  logic [63:0]       insPc;
  logic              fetchFault;

  logic [7:0] mem [1024];

  int n_pass;
  int n_total;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic [63:0] pc;
    logic        fault;
    logic        next_fault;
  } vec_t;

  vec_t vecs[8];

  ins_fetch #(
    .RESET_PC  (64'h0),
    .MEM_AW    (MEM_AW),
    .INS_BYTES (4)
  ) dut (
    .clkOut        (clk),
    .rstN          (rstN),
    .raddr         (raddr),
    .rdata         (rdata),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .insValid      (insValid),
    .insReady      (insReady),
    .curIns        (curIns),
    .insPc         (insPc),
    .fetchFault    (fetchFault)
  );

  assign rdata = mem[raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] word_at(input logic [63:0] pc);
    int a;
    a = int'(pc[9:0]);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  function automatic exp_t mk_exp(input logic [63:0] pc);
    exp_t e;
    e.ins = word_at(pc);
    e.pc  = pc;
    return e;
  endfunction

  // Called at the negedge of fetch cycle 0; follows the word until valid.
  task automatic expect_word(input string tag, input logic [63:0] base);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (!insValid && cyc < 20) begin
      if (cyc < 4) check({tag, " raddr"}, 64'(raddr), (base + 64'(cyc)) & 64'h3FF);
      @(negedge clk);
      cyc++;
    end
    check({tag, " valid"}, 64'(insValid), 64'd1);
    check({tag, " latency"}, 64'(cyc), 64'd4);
    check({tag, " sb depth"}, 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, " curIns"}, 64'(curIns), 64'(e.ins));
      check({tag, " insPc"}, insPc, e.pc);
    end
    check({tag, " hold raddr"}, 64'(raddr), (base + 64'd3) & 64'h3FF);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " insValid"}, 64'(insValid), 64'd0);
    check({tag, " fetchFault"}, 64'(fetchFault), 64'd0);
    check({tag, " curIns"}, 64'(curIns), 64'd0);
    check({tag, " insPc"}, insPc, 64'd0);
    check({tag, " raddr"}, 64'(raddr), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37 + 11) & 'hFF);
    mem[0] = 8'h12;
    mem[1] = 8'h34;
    mem[2] = 8'h56;
    mem[3] = 8'h78;

    vecs[0] = '{pc: 64'h2,                   fault: 1'b1, next_fault: 1'b0};
    vecs[1] = '{pc: 64'h400,                 fault: 1'b1, next_fault: 1'b0};
    vecs[2] = '{pc: 64'h0,                   fault: 1'b0, next_fault: 1'b0};
    vecs[3] = '{pc: 64'h3FC,                 fault: 1'b0, next_fault: 1'b1};
    vecs[4] = '{pc: 64'h8000_0000_0000_0000, fault: 1'b1, next_fault: 1'b0};
    vecs[5] = '{pc: 64'h200,                 fault: 1'b0, next_fault: 1'b0};
    vecs[6] = '{pc: 64'h1,                   fault: 1'b1, next_fault: 1'b0};
    vecs[7] = '{pc: 64'h3F8,                 fault: 1'b0, next_fault: 1'b0};

    rstN          = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = 64'd0;
    insReady      = 1'b0;

    #12;
    check_reset_outputs("reset");

    // First word straight out of reset, accepted immediately.
    @(negedge clk);
    rstN     = 1'b1;
    insReady = 1'b1;
    sb_q.push_back(mk_exp(64'h0));
    expect_word("w0", 64'h0);
    check("w0 value", 64'(curIns), 64'h1234_5678);
    @(negedge clk);
    check("w0 accepted valid", 64'(insValid), 64'd0);
    check("w0 next raddr", 64'(raddr), 64'h4);

    // Backpressure on the word at pc 4.
    insReady = 1'b0;
    sb_q.push_back(mk_exp(64'h4));
    expect_word("w4", 64'h4);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("bp valid", 64'(insValid), 64'd1);
      check("bp curIns", 64'(curIns), 64'(word_at(64'h4)));
      check("bp insPc", insPc, 64'h4);
      check("bp raddr", 64'(raddr), 64'h7);
    end
    insReady = 1'b1;
    @(negedge clk);
    check("bp accept raddr", 64'(raddr), 64'h8);
    check("bp accept valid", 64'(insValid), 64'd0);

    // Redirect after two bytes of the word at pc 8 have been captured.
    @(negedge clk);
    check("mid raddr1", 64'(raddr), 64'h9);
    @(negedge clk);
    check("mid raddr2", 64'(raddr), 64'hA);
    redirectValid = 1'b1;
    redirectPc    = 64'h100;
    @(negedge clk);
    redirectValid = 1'b0;
    check("mid redir valid", 64'(insValid), 64'd0);
    sb_q.delete();
    sb_q.push_back(mk_exp(64'h100));
    expect_word("redir100", 64'h100);

    // Accept and redirect on the same edge: redirect wins.
    redirectValid = 1'b1;
    redirectPc    = 64'h8;
    insReady      = 1'b1;
    @(negedge clk);
    redirectValid = 1'b0;
    insReady      = 1'b0;
    check("sim valid", 64'(insValid), 64'd0);
    check("sim raddr", 64'(raddr), 64'h8);
    sb_q.push_back(mk_exp(64'h8));
    expect_word("sim w8", 64'h8);

    // Redirect vector table: faults, recovery and end-of-memory increment.
    for (int v = 0; v < 8; v++) begin
      redirectValid = 1'b1;
      redirectPc    = vecs[v].pc;
      @(negedge clk);
      redirectValid = 1'b0;
      if (vecs[v].fault) begin
        check($sformatf("vec%0d fault", v), 64'(fetchFault), 64'd1);
        check($sformatf("vec%0d valid", v), 64'(insValid), 64'd0);
        check($sformatf("vec%0d raddr", v), 64'(raddr), 64'd0);
        @(negedge clk);
        check($sformatf("vec%0d sticky", v), 64'(fetchFault), 64'd1);
      end else begin
        check($sformatf("vec%0d nofault", v), 64'(fetchFault), 64'd0);
        sb_q.push_back(mk_exp(vecs[v].pc));
        expect_word($sformatf("vec%0d", v), vecs[v].pc);
        insReady = 1'b1;
        @(negedge clk);
        insReady = 1'b0;
        check($sformatf("vec%0d next fault", v), 64'(fetchFault), 64'(vecs[v].next_fault));
        check($sformatf("vec%0d next valid", v), 64'(insValid), 64'd0);
      end
    end

    // Asynchronous reset in the middle of a fetch.
    redirectValid = 1'b1;
    redirectPc    = 64'h40;
    @(negedge clk);
    redirectValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst mid raddr", 64'(raddr), 64'h42);
    #2;
    rstN = 1'b0;
    #1;
    check_reset_outputs("async rst");
    @(negedge clk);
    rstN = 1'b1;
    sb_q.delete();
    sb_q.push_back(mk_exp(64'h0));
    expect_word("post rst", 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
